// File: rtl/cnn_frame_ctrl_pkg.sv
// ============================================================================
// Module      : cnn_pkg
// Description : Shared definitions for the CNN frame sequencer: FSM state
//               encoding, all-channels-valid constant and helpers that derive
//               the frame pixel count and expected result count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnn_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // All four convolution channels reporting a result together
  localparam logic [3:0] C_ALL_VALID = 4'hF;

  // Number of pixels streamed per frame
  function automatic int unsigned calc_total(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  // Number of 3x3 window positions (valid convolution results) per frame
  function automatic int unsigned calc_exp(input int unsigned w, input int unsigned h);
    return (w - 2) * (h - 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cnn_frame_ctrl_if.sv
// ============================================================================
// Module      : cnn_frame_ctrl_if
// Description : Control, pixel-memory and datapath signals of the CNN frame
//               sequencer. Optional macro CNN_FRAME_CTRL_PERF_EN adds the
//               oCycleCount busy-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cnn_frame_ctrl_if #(
  parameter int WI    = 8,
  parameter int ADDRW = 10
);
  logic             iStart;
  logic             iAbort;
  logic             iHold;
  logic             oRdEn;
  logic [ADDRW-1:0] oRdAddr;
  logic [WI-1:0]    iRdData;
  logic [WI-1:0]    oPixel;
  logic             oPixelValid;
  logic [3:0]       iConvValid;
  logic             oBusy;
  logic             oDone;
  logic             oErr;
  logic [15:0]      oOutCount;
`ifdef CNN_FRAME_CTRL_PERF_EN
  logic [31:0]      oCycleCount;
`endif

  // Sequencer side
  modport slave (
    input  iStart, iAbort, iHold, iRdData, iConvValid,
    output oRdEn, oRdAddr, oPixel, oPixelValid, oBusy, oDone, oErr, oOutCount
`ifdef CNN_FRAME_CTRL_PERF_EN
    , output oCycleCount
`endif
  );

  // Controlling / environment side
  modport master (
    output iStart, iAbort, iHold, iRdData, iConvValid,
    input  oRdEn, oRdAddr, oPixel, oPixelValid, oBusy, oDone, oErr, oOutCount
`ifdef CNN_FRAME_CTRL_PERF_EN
    , input oCycleCount
`endif
  );

endinterface

`default_nettype wire

// File: rtl/cnn_frame_addr_gen.sv
// ============================================================================
// Module      : cnn_frame_addr_gen
// Description : Raster read-address counter. Presents the address of the next
//               read, advances on each issued read, returns to zero while
//               cleared and flags the final pixel address.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_frame_addr_gen #(
  parameter int ADDRW = 10,
  parameter int TOTAL = 784
) (
  input  logic             iClk,
  input  logic             iRsn,
  input  logic             iClr,
  input  logic             iAdv,
  output logic [ADDRW-1:0] oAddr,
  output logic             oLast
);

  localparam logic [ADDRW-1:0] C_LAST_ADDR = ADDRW'(TOTAL - 1);

  logic [ADDRW-1:0] r_addr;
  logic [ADDRW-1:0] w_cur;

  // Clear acts immediately so a read can issue at address 0 on the start cycle
  always_comb begin
    w_cur = iClr ? '0 : r_addr;
  end

  assign oAddr = w_cur;
  assign oLast = (w_cur == C_LAST_ADDR);

  // Advance past the issued address, otherwise hold (or settle to zero)
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_addr <= '0;
    end else if (iAdv) begin
      r_addr <= w_cur + 1'b1;
    end else begin
      r_addr <= w_cur;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cnn_frame_ctrl.sv
// ============================================================================
// Module      : cnn_frame_ctrl
// Description : CNN frame sequencer. Streams one IMG_W x IMG_H image from the
//               pixel memory in raster order, honours downstream hold, counts
//               4-channel convolution results and reports done / error.
//               Optional macro CNN_FRAME_CTRL_PERF_EN adds oCycleCount.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnn_frame_ctrl
  import cnn_pkg::*;
#(
  parameter int WI        = 8,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int ADDRW     = 10,
  parameter int DRAIN_MAX = 64
) (
  input  logic            iClk,
  input  logic            iRsn,
  cnn_frame_ctrl_if.slave bus
);

  localparam int          C_TOTAL    = int'(calc_total(IMG_W, IMG_H));
  localparam logic [15:0] C_EXP      = 16'(calc_exp(IMG_W, IMG_H));
  localparam int          TW         = $clog2(DRAIN_MAX + 1);
  localparam logic [TW-1:0] C_TMO_LAST = TW'(DRAIN_MAX - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_issue;
  logic             w_tmo_err;
  logic [ADDRW-1:0] w_addr;
  logic             w_last;
  logic             r_rd_en;
  logic [ADDRW-1:0] r_rd_addr;
  logic             r_pix_valid;
  logic [WI-1:0]    r_pixel;
  logic [15:0]      r_cnt;
  logic [15:0]      w_cnt_nxt;
  logic             r_err;
  logic             w_set_err;
  logic [TW-1:0]    r_tmo;
  logic             w_start_ok;
  logic             w_count_en;
  logic             w_full;
  logic             w_partial;

  cnn_frame_addr_gen #(
    .ADDRW (ADDRW),
    .TOTAL (C_TOTAL)
  ) u_addr_gen (
    .iClk  (iClk),
    .iRsn  (iRsn),
    .iClr  (r_state != ST_FETCH),
    .iAdv  (w_issue),
    .oAddr (w_addr),
    .oLast (w_last)
  );

  // Result qualification and saturating count of full 4-channel results
  always_comb begin
    w_start_ok = (r_state == ST_IDLE) && bus.iStart && !bus.iAbort;
    w_count_en = ((r_state == ST_FETCH) || (r_state == ST_DRAIN)) && !bus.iAbort;
    w_full     = (bus.iConvValid == C_ALL_VALID);
    w_partial  = (bus.iConvValid != 4'h0) && !w_full;
    w_cnt_nxt  = r_cnt;
    if (w_count_en && w_full && (r_cnt != 16'hFFFF)) begin
      w_cnt_nxt = r_cnt + 16'd1;
    end
  end

  // Next-state and read-issue decision; abort overrides everything
  always_comb begin
    w_next    = r_state;
    w_issue   = 1'b0;
    w_tmo_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.iStart) begin
          w_next  = ST_FETCH;
          w_issue = !bus.iHold;
        end
      end
      ST_FETCH: begin
        w_issue = !bus.iHold;
        if (w_issue && w_last) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // A result landing on the timeout cycle completes the frame cleanly
        if (w_cnt_nxt == C_EXP) begin
          w_next = ST_DONE;
        end else if (r_tmo == C_TMO_LAST) begin
          w_next    = ST_DONE;
          w_tmo_err = 1'b1;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (bus.iAbort) begin
      w_next    = ST_IDLE;
      w_issue   = 1'b0;
      w_tmo_err = 1'b0;
    end
    w_set_err = (w_count_en && (w_partial || (w_full && (r_cnt >= C_EXP)))) || w_tmo_err;
  end

  // State register
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Registered read strobe and address; address holds between reads
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_en <= w_issue;
      if (w_issue) begin
        r_rd_addr <= w_addr;
      end
    end
  end

  // Pixel capture one cycle behind the read; abort drops the in-flight pixel
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_pix_valid <= 1'b0;
      r_pixel     <= '0;
    end else begin
      r_pix_valid <= r_rd_en && !bus.iAbort;
      if (r_rd_en) begin
        r_pixel <= bus.iRdData;
      end
    end
  end

  // Result count and sticky error, both cleared by an accepted start
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_start_ok) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_set_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Drain timeout counter, runs only while draining
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_tmo <= '0;
    end else if ((r_state == ST_DRAIN) && !bus.iAbort) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end

`ifdef CNN_FRAME_CTRL_PERF_EN
  logic [31:0] r_cyc;

  // Busy-cycle counter, saturating, holds after the frame ends
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_cyc <= '0;
    end else if (w_start_ok) begin
      r_cyc <= '0;
    end else if (bus.oBusy && (r_cyc != 32'hFFFF_FFFF)) begin
      r_cyc <= r_cyc + 32'd1;
    end
  end

  assign bus.oCycleCount = r_cyc;
`endif

  assign bus.oRdEn       = r_rd_en;
  assign bus.oRdAddr     = r_rd_addr;
  assign bus.oPixel      = r_pixel;
  assign bus.oPixelValid = r_pix_valid;
  assign bus.oBusy       = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign bus.oDone       = (r_state == ST_DONE);
  assign bus.oErr        = r_err;
  assign bus.oOutCount   = r_cnt;

endmodule

`default_nettype wire

// File: doc/cnn_frame_ctrl.md
# cnn_frame_ctrl

Frame sequencer for the CNN convolution pipeline. On a start pulse it streams one IMG_W×IMG_H image from a synchronous pixel memory into the sliding-window/kernel datapath in raster order, honours a downstream hold, counts the 4-channel convolution results and reports completion or error. It sits between the image buffer and the convolution top level and is the only agent that drives its pixel input.

## Interface
- WI, 8: pixel width in bits
- IMG_W, 28: image width in pixels (≥3)
- IMG_H, 28: image height in pixels (≥3)
- ADDRW, 10: memory address width; 2^ADDRW ≥ IMG_W·IMG_H
- DRAIN_MAX, 64: drain-phase timeout in cycles

- iClk  in  1  clock
- iRsn  in  1  reset, asynchronous, active-low
- iStart  in  1  start pulse; accepted only in IDLE
- iAbort  in  1  abort; wins over every other input
- iHold  in  1  downstream not ready; suppresses new reads
- oRdEn  out  1  memory read strobe
- oRdAddr  out  ADDRW  memory read address
- iRdData  in  WI  read data, valid 1 cycle after oRdEn
- oPixel  out  WI  pixel to datapath
- oPixelValid  out  1  pixel qualifier
- iConvValid  in  4  per-channel result valid from datapath
- oBusy  out  1  high in FETCH and DRAIN
- oDone  out  1  1-cycle completion pulse
- oErr  out  1  sticky error, cleared by next accepted iStart
- oOutCount  out  16  results counted this frame

## Operation
- FSM: IDLE, FETCH, DRAIN, DONE. Encoded in shared package.
- IDLE: iStart → FETCH; address, counters, oErr cleared.
- FETCH: each cycle with iHold=0 issues oRdEn=1 at oRdAddr, then address +1. Issue at address IMG_W·IMG_H−1 → DRAIN next cycle. iHold=1: oRdEn=0, address held.
- Pixel path: oPixelValid = oRdEn delayed 1 cycle; oPixel = iRdData registered alongside. A read in flight when iHold rises is still delivered (downstream tolerates one pixel after hold).
- Result counting (FETCH and DRAIN): iConvValid==4'hF → oOutCount+1. Any partial pattern (nonzero, not 4'hF) sets oErr, not counted.
- EXP = (IMG_W−2)·(IMG_H−2), compile-time constant.
- DRAIN: timeout counter runs from 0. oOutCount==EXP → DONE. Counter reaches DRAIN_MAX−1 first → DONE with oErr set. Result arriving in same cycle as timeout counts and wins (no error).
- Count exceeding EXP in any state sets oErr; counter saturates at 16'hFFFF.
- DONE: oDone=1 for one cycle, → IDLE. oOutCount and oErr hold until next accepted iStart.
- iStart outside IDLE ignored. iAbort in any state → IDLE next cycle, no oDone, in-flight pixel dropped (oPixelValid forced 0 that cycle), oErr unchanged.

## Timing
- Reset: state IDLE; oRdEn, oPixelValid, oBusy, oDone, oErr = 0; oRdAddr, oPixel, oOutCount = 0.
- iStart at cycle n → oBusy and first oRdEn at n+1, first oPixelValid at n+2.
- No hold: IMG_W·IMG_H consecutive oRdEn cycles, no bubbles, including across row boundaries.
- All outputs registered; no combinational input→output path.
- oDone one cycle after the last counting cycle; oBusy low in same cycle as oDone.

## Configuration
- CNN_FRAME_CTRL_PERF_EN defined: extra output oCycleCount[31:0], cleared on accepted iStart, increments every cycle while oBusy, holds after DONE/abort, saturates at all-ones.
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package cnn_pkg: FSM state enum, EXP and total pixel count computed from IMG_W/IMG_H, and the 4'hF all-valid constant.
- One sub-module: cnn_frame_addr_gen — address counter with hold/clear and last-address flag.

## Test plan
- IMG_W=IMG_H=5, iStart, no hold, datapath model returns 9 results → 25 consecutive reads addr 0..24, oPixel equals memory contents one cycle later, oOutCount=9, oDone one pulse, oErr=0.
- Same, iHold high for 3 cycles at address 7 → exactly 1 pixel after hold rises, reads resume at addr 8, 25 pixels total, no duplicates.
- Model returns only 8 results → DRAIN times out after 64 cycles, oDone pulses, oErr=1, oOutCount=8.
- iConvValid=4'b0111 once → oErr=1, that event not counted.
- iAbort at address 12 → IDLE next cycle, no oDone, oPixelValid 0; new iStart restarts at addr 0 with oErr cleared.
- iStart held high during FETCH → ignored; with CNN_FRAME_CTRL_PERF_EN, oCycleCount equals measured busy cycles.
